// File: rtl/pipe_delay_line_pkg.sv
// pipe_delay_line_pkg: legal parameter limits and a range helper for the delay line.
`default_nettype none

package pipe_delay_line_pkg;

    localparam int MAX_STAGES = 64;
    localparam int MAX_WIDTH  = 256;

    function automatic bit params_legal(input int stages, input int width);
        return (stages >= 1) && (stages <= MAX_STAGES) &&
               (width  >= 1) && (width  <= MAX_WIDTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_delay_line.sv
// pipe_delay_line: resettable STAGES-deep shift-register delay line with a full tap bus.
// Rev 1.0
`default_nettype none

module pipe_delay_line
    import pipe_delay_line_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int WIDTH  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        val_in,
    output logic [WIDTH-1:0]        val_out,
    input  logic [STAGES*WIDTH-1:0] pipe_in,
    output logic [STAGES*WIDTH-1:0] pipe_out
);

    if (!params_legal(STAGES, WIDTH)) begin : g_param_check
        $fatal(1, "pipe_delay_line: STAGES=%0d WIDTH=%0d out of range", STAGES, WIDTH);
    end

    // Cascade port is reserved; reduce it into a deliberately unused net so nothing reaches the outputs.
    logic unused_pipe_in;
    assign unused_pipe_in = ^pipe_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] q;

        if (k == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= val_in;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= g_stage[k-1].q;
                end
            end
        end

        assign pipe_out[k*WIDTH +: WIDTH] = q;
    end

    assign val_out = g_stage[STAGES-1].q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_delay_line.sv
// tb_pipe_delay_line: randomized self-checking bench for two delay-line configurations.
`default_nettype none

module tb_pipe_delay_line;

    localparam int SA = 3;
    localparam int WA = 2;
    localparam int SB = 1;
    localparam int WB = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [WA-1:0]     val_in_a = '0;
    logic [WA-1:0]     val_out_a;
    logic [SA*WA-1:0]  pipe_in_a = '0;
    logic [SA*WA-1:0]  pipe_out_a;
    logic [WB-1:0]     val_in_b = '0;
    logic [WB-1:0]     val_out_b;
    logic [SB*WB-1:0]  pipe_in_b = '0;
    logic [SB*WB-1:0]  pipe_out_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: history of words accepted by the line, newest first.
    logic [WA-1:0] hist_a[$];
    logic [WB-1:0] hist_b[$];

    always #5 clk = ~clk;

    pipe_delay_line #(.STAGES(SA), .WIDTH(WA)) dut_a (
        .clk(clk), .reset(reset), .val_in(val_in_a), .val_out(val_out_a),
        .pipe_in(pipe_in_a), .pipe_out(pipe_out_a)
    );

    pipe_delay_line #(.STAGES(SB), .WIDTH(WB)) dut_b (
        .clk(clk), .reset(reset), .val_in(val_in_b), .val_out(val_out_b),
        .pipe_in(pipe_in_b), .pipe_out(pipe_out_b)
    );

    function automatic logic [SA*WA-1:0] exp_taps_a();
        logic [SA*WA-1:0] v;
        for (int k = 0; k < SA; k++) v[k*WA +: WA] = hist_a[k];
        return v;
    endfunction

    function automatic logic [SB*WB-1:0] exp_taps_b();
        logic [SB*WB-1:0] v;
        for (int k = 0; k < SB; k++) v[k*WB +: WB] = hist_b[k];
        return v;
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            hist_a.delete();
            hist_b.delete();
            for (int k = 0; k < SA; k++) hist_a.push_back('0);
            for (int k = 0; k < SB; k++) hist_b.push_back('0);
        end else begin
            hist_a.push_front(val_in_a);
            void'(hist_a.pop_back());
            hist_b.push_front(val_in_b);
            void'(hist_b.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        val_in_a = 2'b11;
        val_in_b = 8'hA5;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (val_out_a !== 2'b00) begin
            n_bad++; $display("FAIL reset_val_out_a got=%b want=00", val_out_a);
        end
        n_cmp++;
        if (pipe_out_a !== 6'b000000) begin
            n_bad++; $display("FAIL reset_pipe_out_a got=%b want=000000", pipe_out_a);
        end
        n_cmp++;
        if (val_out_b !== 8'h00 || pipe_out_b !== 8'h00) begin
            n_bad++; $display("FAIL reset_b got val=%h taps=%h want=00/00", val_out_b, pipe_out_b);
        end
        val_in_a = '0;
        val_in_b = '0;
        tick();
    endtask

    task automatic test_single_pulse();
        logic [SA*WA-1:0] want_taps[5];
        want_taps = '{6'b000001, 6'b000100, 6'b010000, 6'b000000, 6'b000000};
        val_in_a = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            val_in_a = 2'b00;
            n_cmp++;
            if (pipe_out_a !== want_taps[i] || val_out_a !== want_taps[i][5:4]) begin
                n_bad++;
                $display("FAIL pulse_cycle%0d got taps=%b out=%b want taps=%b out=%b",
                         i, pipe_out_a, val_out_a, want_taps[i], want_taps[i][5:4]);
            end
        end
    endtask

    task automatic test_sequence();
        logic [WA-1:0] seq[5];
        logic [WA-1:0] want;
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        for (int i = 0; i < 9; i++) begin
            val_in_a = (i < 5) ? seq[i] : 2'd0;
            tick();
            want = (i >= 2 && i - 2 < 5) ? seq[i-2] : 2'd0;
            n_cmp++;
            if (val_out_a !== want || pipe_out_a !== exp_taps_a()) begin
                n_bad++;
                $display("FAIL sequence_cycle%0d got out=%0d taps=%b want out=%0d taps=%b",
                         i, val_out_a, pipe_out_a, want, exp_taps_a());
            end
        end
    endtask

    task automatic test_reset_midflight();
        val_in_a = 2'b11;
        repeat (SA) tick();
        n_cmp++;
        if (pipe_out_a !== 6'b111111) begin
            n_bad++; $display("FAIL midflight_load got=%b want=111111", pipe_out_a);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (val_out_a !== 2'b00 || pipe_out_a !== 6'b000000) begin
            n_bad++; $display("FAIL midflight_flush got out=%b taps=%b want 00/000000", val_out_a, pipe_out_a);
        end
        for (int i = 0; i < 6; i++) begin
            val_in_a = 2'($urandom_range(1, 3));
            tick();
            n_cmp++;
            if (val_out_a !== hist_a[SA-1] || pipe_out_a !== exp_taps_a()) begin
                n_bad++;
                $display("FAIL midflight_refill_cycle%0d got out=%b taps=%b want out=%b taps=%b",
                         i, val_out_a, pipe_out_a, hist_a[SA-1], exp_taps_a());
            end
        end
    endtask

    task automatic test_reset_coincident();
        val_in_a = 2'b10;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        val_in_a = 2'b00;
        for (int i = 0; i < SA + 2; i++) begin
            n_cmp++;
            if (val_out_a !== 2'b00 || pipe_out_a !== 6'b000000) begin
                n_bad++;
                $display("FAIL coincident_cycle%0d got out=%b taps=%b want 00/000000", i, val_out_a, pipe_out_a);
            end
            tick();
        end
    endtask

    task automatic test_pipe_in_ignored();
        for (int i = 0; i < 40; i++) begin
            val_in_a = 2'($urandom);
            if (i % 3 == 0) pipe_in_a = 'x;
            else            pipe_in_a = 6'($urandom);
            pipe_in_b = (i % 2 == 0) ? 8'($urandom) : 'x;
            tick();
            n_cmp++;
            if (val_out_a !== hist_a[SA-1] || pipe_out_a !== exp_taps_a()) begin
                n_bad++;
                $display("FAIL pipe_in_cycle%0d got out=%b taps=%b want out=%b taps=%b",
                         i, val_out_a, pipe_out_a, hist_a[SA-1], exp_taps_a());
            end
        end
        pipe_in_a = '0;
        pipe_in_b = '0;
    endtask

    task automatic test_stage1();
        logic [WB-1:0] prev;
        for (int i = 0; i < 40; i++) begin
            prev = 8'($urandom);
            val_in_b = prev;
            val_in_a = 2'($urandom);
            if (i % 4 == 1) pipe_in_b = 'x;
            tick();
            n_cmp++;
            if (val_out_b !== prev || pipe_out_b !== exp_taps_b() || pipe_out_b !== prev) begin
                n_bad++;
                $display("FAIL stage1_cycle%0d got out=%h taps=%h want %h", i, val_out_b, pipe_out_b, prev);
            end
            pipe_in_b = '0;
        end
        val_in_b = '0;
    endtask

    initial begin
        for (int k = 0; k < SA; k++) hist_a.push_back('0);
        for (int k = 0; k < SB; k++) hist_b.push_back('0);
        #2;
        test_reset();
        test_single_pulse();
        test_sequence();
        test_reset_midflight();
        test_reset_coincident();
        test_pipe_in_ignored();
        test_stage1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
